// File: rtl/vga_timing.sv
// Purpose : free-running 1024x768@60 pixel-timing generator producing the VGA bus and a frame-start strobe.
// Latency : every bus field is registered from next-state counters, so all fields line up with hcount/vcount; zero extra latency.
// Backpressure: none; the generator never stalls and has no enable, it runs continuously once out of reset.
//
// Ports:
//   pclk        in   pixel clock (65 MHz), rising edge
//   rst_n       in   asynchronous active-low reset; forces pixel (0,0) state
//   vga_out     out  VGA bus, layout vga_pkg::vga_bus_t {hcount, vcount, hs, vs, hblnk, vblnk, rgb}
//   frame_start out  one-cycle pulse when the bus wraps from the last pixel to (0,0)

package vga_pkg;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hs;
    logic        vs;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  localparam int VGA_BUS_SIZE = $bits(vga_bus_t);

endpackage

module vga_timing #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                              pclk,
  input  logic                              rst_n,
  output logic [vga_pkg::VGA_BUS_SIZE-1:0]  vga_out,
  output logic                              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap, v_wrap;
  logic        in_hsync, in_vsync;

  vga_pkg::vga_bus_t bus;

  // Next-state counters and decode. Decoding the *next* counter values and
  // registering the result keeps sync/blank aligned with the registered counts.
  always_comb begin
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);

    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
    end

    in_hsync = (hcount_d >= H_SYNC_START) && (hcount_d <= H_SYNC_END);
    in_vsync = (vcount_d >= V_SYNC_START) && (vcount_d <= V_SYNC_END);

    hblnk_d  = (hcount_d >= H_BLNK_START);
    vblnk_d  = (vcount_d >= V_BLNK_START);
    hs_d     = in_hsync ? SYNC_POL : ~SYNC_POL;
    vs_d     = in_vsync ? SYNC_POL : ~SYNC_POL;

    // Only the last pixel of the last line leads into (0,0); the reset state
    // is (0,0) too but never passes through here, so it produces no strobe.
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Colour is supplied by downstream draw stages; this stage carries black.
  always_comb begin
    bus        = '0;
    bus.hcount = hcount_q;
    bus.vcount = vcount_q;
    bus.hs     = hs_q;
    bus.vs     = vs_q;
    bus.hblnk  = hblnk_q;
    bus.vblnk  = vblnk_q;
    bus.rgb    = 12'h000;
  end

  assign vga_out     = bus;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;
  import vga_pkg::*;

  // Full-size 1024x768 timing (active-low sync).
  localparam int A_HA = 1024, A_HFP = 24, A_HS = 136, A_HBP = 160;
  localparam int A_VA = 768,  A_VFP = 3,  A_VS = 6,   A_VBP = 29;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_FRAME = A_HT * (A_VA + A_VFP + A_VS + A_VBP);

  // Miniature timing with active-high sync so whole frames fit in a short run.
  localparam int B_HA = 8, B_HFP = 2, B_HS = 3, B_HBP = 4;
  localparam int B_VA = 5, B_VFP = 1, B_VS = 2, B_VBP = 2;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_FRAME = B_HT * (B_VA + B_VFP + B_VS + B_VBP);

  localparam int SEG1_STEPS = 1400;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic [VGA_BUS_SIZE-1:0] out_a, out_b;
  logic fs_a, fs_b;
  vga_bus_t bus_a, bus_b;

  assign bus_a = out_a;
  assign bus_b = out_b;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  n = 0;
  bit  seg1 = 1'b0;
  int  a_hs_low = 0;
  int  a_hblnk_rise_h = -1;
  int  b_vs_act = 0;
  int  b_last_pulse = -1;
  int  b_pulses = 0;
  logic prev_a_hblnk = 1'b0;
  logic prev_b_vs = 1'b0;

  always #5 pclk = ~pclk;

  vga_timing dut_a (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vga_out     (out_a),
    .frame_start (fs_a)
  );

  vga_timing #(
    .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
    .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP),
    .SYNC_POL (1'b1)
  ) dut_b (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vga_out     (out_b),
    .frame_start (fs_b)
  );

  // Reference: the bus after `cyc` clock edges since reset release is simply
  // the pixel at linear position cyc mod frame-length.
  function automatic vga_bus_t model(input int cyc,
                                     input int ha, input int hfp, input int hsw, input int hbp,
                                     input int va, input int vfp, input int vsw, input int vbp,
                                     input bit pol);
    vga_bus_t m;
    int ht, vt, p, h, v;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p  = cyc % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    m        = '0;
    m.hcount = 11'(h);
    m.vcount = 11'(v);
    m.hblnk  = (h >= ha);
    m.vblnk  = (v >= va);
    m.hs     = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
    m.vs     = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
    m.rgb    = 12'h000;
    return m;
  endfunction

  function automatic vga_bus_t model_a(input int cyc);
    return model(cyc, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, 1'b0);
  endfunction

  function automatic vga_bus_t model_b(input int cyc);
    return model(cyc, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_bus", bus_a, model_a(n));
    chk("a_frame_start", fs_a, (n > 0) && (n % A_FRAME == 0));
    chk("b_bus", bus_b, model_b(n));
    chk("b_frame_start", fs_b, (n > 0) && (n % B_FRAME == 0));
  endtask

  task automatic step();
    @(posedge pclk);
    n++;
    #2;
    check_all();
    if (seg1 && n < A_HT && bus_a.hs == 1'b0) a_hs_low++;
    if (seg1 && !prev_a_hblnk && bus_a.hblnk && a_hblnk_rise_h < 0)
      a_hblnk_rise_h = int'(bus_a.hcount);
    prev_a_hblnk = bus_a.hblnk;
    if (bus_b.vs !== prev_b_vs) chk("b_vs_edge_at_h0", bus_b.hcount, 0);
    prev_b_vs = bus_b.vs;
    if (seg1 && n >= B_FRAME && n < 2 * B_FRAME && bus_b.vs) b_vs_act++;
    if (fs_b) begin
      if (b_last_pulse >= 0) chk("b_fs_interval", n - b_last_pulse, B_FRAME);
      else                   chk("b_fs_first", n, B_FRAME);
      b_last_pulse = n;
      b_pulses++;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a_bus"}, bus_a, model_a(0));
    chk({tag, "_a_hs"}, bus_a.hs, 1'b1);
    chk({tag, "_a_vs"}, bus_a.vs, 1'b1);
    chk({tag, "_a_fs"}, fs_a, 1'b0);
    chk({tag, "_b_bus"}, bus_b, model_b(0));
    chk({tag, "_b_hs"}, bus_b.hs, 1'b0);
    chk({tag, "_b_vs"}, bus_b.vs, 1'b0);
    chk({tag, "_b_fs"}, fs_b, 1'b0);
  endtask

  initial begin
    int k;
    int hold;
    int off;

    // Power-on reset held for 5 edges.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk);
      #2;
      check_reset("por");
    end
    #1 rst_n = 1'b1;
    n = 0;
    seg1 = 1'b1;
    prev_a_hblnk = 1'b0;
    prev_b_vs = 1'b0;

    // First edge after release shows (1,0).
    step();
    chk("a_first_hcount", bus_a.hcount, 1);
    chk("a_first_vcount", bus_a.vcount, 0);

    // Free run through the first full-size line and many miniature frames.
    while (n < SEG1_STEPS) step();
    chk("a_hblnk_rise_h", a_hblnk_rise_h, A_HA);
    chk("a_hs_low_cycles", a_hs_low, A_HS);
    chk("a_line1_vcount", bus_a.vcount, 1);
    chk("b_vs_active_cycles", b_vs_act, B_VS * B_HT);
    chk("b_pulse_count", b_pulses, SEG1_STEPS / B_FRAME);
    seg1 = 1'b0;

    // Random extra run, then an asynchronous reset between clock edges.
    k = $urandom_range(30, 300);
    for (int i = 0; i < k; i++) step();
    if (n % B_FRAME == 0) step();
    @(posedge pclk);
    n++;
    #2;
    check_all();
    off = $urandom_range(1, 4);
    #(off) rst_n = 1'b0;
    #1;
    check_reset("async");

    hold = $urandom_range(1, 4);
    for (int i = 0; i < hold; i++) begin
      @(posedge pclk);
      #2;
      check_reset("hold");
    end
    #1 rst_n = 1'b1;
    n = 0;
    b_last_pulse = -1;
    prev_a_hblnk = 1'b0;
    prev_b_vs = 1'b0;

    step();
    chk("restart_a_hcount", bus_a.hcount, 1);
    chk("restart_a_vcount", bus_a.vcount, 0);
    chk("restart_b_hcount", bus_b.hcount, 1);

    // Enough to see the first post-restart strobe (no partial-frame pulse).
    while (n < 2 * B_FRAME + 20) step();
    chk("restart_b_pulse_seen", b_last_pulse, 2 * B_FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
